// File: rtl/soustracteur_32bit_seq_pkg.sv
// Shared types for the multi-cycle subtractor: FSM state encodings
// (ST_IDLE / ST_CALC / ST_DONE) and a slice-count helper.
package soustracteur_32bit_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter able to hold 0..n-1 (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soustracteur_32bit_seq_slice.sv
// Combinational W-bit subtract slice: {s_o} = a_i - b_i - bin_i.
// Ports: a_i, b_i (W), bin_i borrow-in; s_o (W), bout_o borrow-out.
module soustracteur_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] s_o,
  output logic         bout_o
);

  logic c;

  // a - b - bin == a + ~b + !bin; carry-out is the inverted borrow.
  assign {c, s_o} = {1'b0, a_i} + {1'b0, ~b_i}
                  + {{W{1'b0}}, ~bin_i};
  assign bout_o = ~c;

endmodule

// File: rtl/soustracteur_32bit_seq.sv
// Multi-cycle WIDTH-bit subtractor s = a - b - bin, one SLICE per cycle.
// Ports: clk, rst (sync, active high); a, b, bin, in_valid -> in_ready;
// s, bout, out_valid <- out_ready; ovf only with SOUSTRACTEUR_OVF_EN.
module soustracteur_32bit_seq
  import soustracteur_32bit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SOUSTRACTEUR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_w(NSLICE);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("WIDTH must be a multiple of SLICE");
  end

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_d;
  logic [NSLICE-1:0][SLICE-1:0] b_q, b_d;
  logic [NSLICE-1:0][SLICE-1:0] s_q, s_d;
  logic brw_q, brw_d;
  logic bout_q, bout_d;

  logic [SLICE-1:0] sl_s;
  logic             sl_bout;
  logic             last;

  soustracteur_slice #(
    .W (SLICE)
  ) u_slice (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .bin_i  (brw_q),
    .s_o    (sl_s),
    .bout_o (sl_bout)
  );

  assign last = (idx_q == IW'(NSLICE - 1));

`ifdef SOUSTRACTEUR_OVF_EN
  logic ovf_q, ovf_d;
  // Overflow only when operand signs differ and the result sign
  // departs from the minuend; the result MSB lives in the last slice.
  logic ovf_now;
  assign ovf_now = (a_q[NSLICE-1][SLICE-1] != b_q[NSLICE-1][SLICE-1])
                && (sl_s[SLICE-1] != a_q[NSLICE-1][SLICE-1]);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef SOUSTRACTEUR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d[idx_q] = sl_s;
        brw_d      = sl_bout;
        idx_d      = idx_q + IW'(1);
        if (last) begin
          idx_d   = '0;
          bout_d  = sl_bout;
          state_d = ST_DONE;
`ifdef SOUSTRACTEUR_OVF_EN
          ovf_d   = ovf_now;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SOUSTRACTEUR_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_soustracteur_32bit_seq.sv
// Directed bench for soustracteur_32bit_seq: hand-computed vectors,
// handshake timing, hold in DONE, busy-ignore and mid-op reset.
module tb_soustracteur_32bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        bout;
  logic        out_valid;
  logic        out_ready;
`ifdef SOUSTRACTEUR_OVF_EN
  logic        ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  soustracteur_32bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SOUSTRACTEUR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full operation. busy: keep in_valid high with junk operands
  // from the transfer until the consume edge. hold: cycles in DONE
  // with out_ready low before consuming.
  task automatic run(input string tag,
                     input logic [31:0] va, vb,
                     input logic vbin,
                     input logic [31:0] es,
                     input logic eb, eo,
                     input logic busy,
                     input int hold);
    int lat;
    logic [31:0] s0;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = busy;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1;
    chk({tag, ".busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, 2);
    chk({tag, ".s"}, s, es);
    chk({tag, ".bout"}, bout, eb);
`ifdef SOUSTRACTEUR_OVF_EN
    chk({tag, ".ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    s0 = s;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_s"}, s, s0);
      chk({tag, ".hold_b"}, bout, eb);
      chk({tag, ".hold_v"}, out_valid, 1);
      chk({tag, ".hold_r"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".done_v"}, out_valid, 0);
    chk({tag, ".done_r"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; bin = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.s", s, 0);
    chk("rst.bout", bout, 0);
`ifdef SOUSTRACTEUR_OVF_EN
    chk("rst.ovf", ovf, 0);
`endif

    run("t1", 32'h5, 32'h3, 0, 32'h2, 0, 0, 0, 5);
    run("t2", 32'h0, 32'h1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    run("t3", 32'h0001_0000, 32'h1, 0, 32'h0000_FFFF, 0, 0, 0, 0);
    run("t4", 32'h1234_5678, 32'h1234_5678, 1,
        32'hFFFF_FFFF, 1, 0, 1, 2);
    run("t5", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
        32'hFFFF_FFFF, 1, 0, 0, 0);
    run("t6", 32'hFFFF_FFFF, 32'h0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    run("t7", 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 0, 1, 0, 0);
    run("t8", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0,
        32'h8000_0000, 1, 1, 0, 1);

    // Reset while in CALC aborts the operation.
    @(negedge clk);
    a = 32'h9; b = 32'h1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.in_ready", in_ready, 1);
    chk("abort.s", s, 0);
    chk("abort.bout", bout, 0);
`ifdef SOUSTRACTEUR_OVF_EN
    chk("abort.ovf", ovf, 0);
`endif
    run("t9", 32'h5, 32'h3, 0, 32'h2, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
